// File: rtl/mc_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Multicycle MIPS-subset main control FSM. It sequences fetch,
//               decode and per-instruction execution states for lw, sw,
//               R-type, beq, addi and j, and derives the datapath controls.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEXE = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] next_state;
  logic [2:0] funct_alu;
  logic       funct_legal;
  logic       pcwrite;
  logic       branch;
  logic       memwrite_raw;
  logic       irwrite_raw;
  logic       regwrite_raw;

  // State register; reset always returns to FETCH, aborting any instruction
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // R-type funct decode; an unknown funct falls back to add and is flagged
  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default: begin
        funct_alu   = ALU_ADD;
        funct_legal = 1'b0;
      end
    endcase
  end

  // Next-state logic; op/funct only matter in DECODE, MEMADR and EXECUTE
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEXE;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:  next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   next_state = S_MEMWB;
      S_EXECUTE: next_state = funct_legal ? S_ALUWB : S_FETCH;
      S_ADDIEXE: next_state = S_ADDIWB;
      default:   next_state = S_FETCH;
    endcase
  end

  // Moore outputs per state; only EXECUTE's ALU code also looks at funct
  always_comb begin
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    alucontrol   = ALU_ADD;
    pcsrc        = 2'b00;
    case (state)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        alusrcb     = 2'b01;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      S_ADDIEXE: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB:  regwrite_raw = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      // Unused encodings 12-15 drive everything, including the ALU code, low
      default:   alucontrol = 3'b000;
    endcase
  end

  // Write enables are squashed while reset is high so an aborted write is lost
  assign memwrite = memwrite_raw & ~reset;
  assign irwrite  = irwrite_raw  & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller
// Description : Directed self-checking bench for mc_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic [1:0] pcsrc;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memwrite   (memwrite),
    .iord       (iord),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .pcsrc      (pcsrc),
    .state      (state)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Write strobes packed as {memwrite, regwrite, irwrite, pcen}
  function automatic logic [7:0] wr();
    return {4'b0, memwrite, regwrite, irwrite, pcen};
  endfunction

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    funct = 6'b100000;
    zero  = 1'b0;

    // Reset: state forced to FETCH, strobes held low while reset is high
    step();
    step();
    chk("rst_state", {4'b0, state}, 8'd0);
    chk("rst_writes_gated", wr(), 8'b0000);

    reset = 1'b0;
    #1;
    chk("fetch_writes", wr(), 8'b0011);
    chk("fetch_alusrcb", {6'b0, alusrcb}, 8'd1);
    chk("fetch_aluctl", {5'b0, alucontrol}, 8'd2);

    // addi: 0,1,9,10,0
    op = 6'b001000;
    step(); chk("addi_s1", {4'b0, state}, 8'd1);
    chk("decode_alusrcb", {6'b0, alusrcb}, 8'd3);
    chk("decode_writes", wr(), 8'b0000);
    step(); chk("addi_s9", {4'b0, state}, 8'd9);
    chk("addiexe_src", {5'b0, alusrca, alusrcb}, 8'b110);
    chk("addiexe_regwrite", {7'b0, regwrite}, 8'd0);
    step(); chk("addi_s10", {4'b0, state}, 8'd10);
    chk("addiwb_rw_dst_m2r", {5'b0, regwrite, regdst, memtoreg}, 8'b100);
    step(); chk("addi_end", {4'b0, state}, 8'd0);

    // slt: 0,1,6,7,0
    op = 6'b000000; funct = 6'b101010;
    step(); chk("slt_s1", {4'b0, state}, 8'd1);
    step(); chk("slt_s6", {4'b0, state}, 8'd6);
    chk("slt_aluctl", {5'b0, alucontrol}, 8'd7);
    chk("exec_src", {5'b0, alusrca, alusrcb}, 8'b100);
    chk("exec_regwrite", {7'b0, regwrite}, 8'd0);
    step(); chk("slt_s7", {4'b0, state}, 8'd7);
    chk("aluwb_rw_dst_m2r", {5'b0, regwrite, regdst, memtoreg}, 8'b110);
    step(); chk("slt_end", {4'b0, state}, 8'd0);

    // sub funct decode
    funct = 6'b100010;
    step(); step(); chk("sub_aluctl", {5'b0, alucontrol}, 8'd6);
    step(); step(); chk("sub_end", {4'b0, state}, 8'd0);

    // beq taken
    op = 6'b000100;
    step(); chk("beq_s1", {4'b0, state}, 8'd1);
    zero = 1'b1;
    step(); chk("beq_s8", {4'b0, state}, 8'd8);
    chk("beq_taken_pcen", {7'b0, pcen}, 8'd1);
    chk("beq_pcsrc", {6'b0, pcsrc}, 8'd1);
    chk("beq_aluctl", {5'b0, alucontrol}, 8'd6);
    step(); chk("beq_t_end", {4'b0, state}, 8'd0);
    // beq not taken
    zero = 1'b0;
    step(); step(); chk("beq_nt_s8", {4'b0, state}, 8'd8);
    chk("beq_nt_pcen", {7'b0, pcen}, 8'd0);
    step(); chk("beq_nt_end", {4'b0, state}, 8'd0);

    // sw: 0,1,2,5,0
    op = 6'b101011;
    step(); chk("sw_s1", {4'b0, state}, 8'd1);
    step(); chk("sw_s2", {4'b0, state}, 8'd2);
    chk("memadr_src", {5'b0, alusrca, alusrcb}, 8'b110);
    chk("memadr_mw_iord", {6'b0, memwrite, iord}, 8'b00);
    step(); chk("sw_s5", {4'b0, state}, 8'd5);
    chk("memwr_mw_iord", {6'b0, memwrite, iord}, 8'b11);
    step(); chk("sw_end", {4'b0, state}, 8'd0);
    chk("sw_end_memwrite", {7'b0, memwrite}, 8'd0);

    // lw: 0,1,2,3,4,0; op changed during MEMRD must not matter
    op = 6'b100011;
    step(); step(); chk("lw_s2", {4'b0, state}, 8'd2);
    step(); chk("lw_s3", {4'b0, state}, 8'd3);
    chk("memrd_iord", {7'b0, iord}, 8'd1);
    op = 6'b000010;
    step(); chk("lw_s4", {4'b0, state}, 8'd4);
    chk("memwb_rw_dst_m2r", {5'b0, regwrite, regdst, memtoreg}, 8'b101);
    step(); chk("lw_end", {4'b0, state}, 8'd0);

    // Reset during MEMWR kills the write and returns to FETCH
    op = 6'b101011;
    step(); step(); step(); chk("rsw_s5", {4'b0, state}, 8'd5);
    reset = 1'b1;
    #1;
    chk("rsw_memwrite_gated", {7'b0, memwrite}, 8'd0);
    step(); chk("rsw_state", {4'b0, state}, 8'd0);
    chk("rsw_writes_gated", wr(), 8'b0000);
    reset = 1'b0;
    #1;

    // Unknown op: 0,1,0 with no writes
    op = 6'b111111;
    step(); chk("nop_s1", {4'b0, state}, 8'd1);
    chk("nop_writes", wr(), 8'b0000);
    step(); chk("nop_end", {4'b0, state}, 8'd0);

    // j: 0,1,11,0
    op = 6'b000010;
    step(); step(); chk("j_s11", {4'b0, state}, 8'd11);
    chk("j_pcsrc", {6'b0, pcsrc}, 8'd2);
    chk("j_pcen", {7'b0, pcen}, 8'd1);
    step(); chk("j_end", {4'b0, state}, 8'd0);

    // Illegal funct: EXECUTE with add, then straight back to FETCH
    op = 6'b000000; funct = 6'b111111;
    step(); step(); chk("badf_s6", {4'b0, state}, 8'd6);
    chk("badf_aluctl", {5'b0, alucontrol}, 8'd2);
    step(); chk("badf_end", {4'b0, state}, 8'd0);
    chk("badf_fetch_writes", wr(), 8'b0011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes SHALL occur on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 op  input  6  instruction register bits [31:26].
REQ-005 funct  input  6  instruction register bits [5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 memwrite  output  1  unified memory write enable (drives memory we).
REQ-008 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 irwrite  output  1  instruction register load enable.
REQ-010 pcen  output  1  PC load enable.
REQ-011 regwrite  output  1  register file write enable.
REQ-012 regdst  output  1  destination register select: 0 = rt, 1 = rd.
REQ-013 memtoreg  output  1  writeback select: 0 = ALUOut, 1 = memory data.
REQ-014 alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-015 alusrcb  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
REQ-016 alucontrol  output  3  ALU operation code.
REQ-017 pcsrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-018 state  output  4  current FSM state, for debug.

Function
REQ-019 The FSM SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXE=9, ADDIWB=10, JUMP=11.
REQ-020 Every output not listed as asserted for a state SHALL be 0. Unused selects SHALL be 0, and alucontrol SHALL default to 010 (add).
REQ-021 FETCH: irwrite=1, pcwrite=1, alusrcb=01, alucontrol=010. Next state: DECODE.
REQ-022 DECODE: alusrcb=11, alucontrol=010. Next state by op:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> EXECUTE
- 000100 (beq) -> BRANCH
- 001000 (addi) -> ADDIEXE
- 000010 (j) -> JUMP
- any other op -> FETCH (treated as a nop)
REQ-023 MEMADR: alusrca=1, alusrcb=10, alucontrol=010. Next state: MEMRD for lw, MEMWR for sw.
REQ-024 MEMRD: iord=1. Next state: MEMWB.
REQ-025 MEMWB: regwrite=1, memtoreg=1, regdst=0. Next state: FETCH.
REQ-026 MEMWR: iord=1, memwrite=1. Next state: FETCH.
REQ-027 EXECUTE: alusrca=1, alusrcb=00, alucontrol decoded from funct:
- 100000 -> 010 (add)
- 100010 -> 110 (sub)
- 100100 -> 000 (and)
- 100101 -> 001 (or)
- 101010 -> 111 (slt)
Next state: ALUWB for a legal funct. An illegal funct SHALL give alucontrol=010 and next state FETCH, with no register write.
REQ-028 ALUWB: regwrite=1, regdst=1, memtoreg=0. Next state: FETCH.
REQ-029 BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1. Next state: FETCH.
REQ-030 ADDIEXE: alusrca=1, alusrcb=10, alucontrol=010. Next state: ADDIWB.
REQ-031 ADDIWB: regwrite=1, regdst=0, memtoreg=0. Next state: FETCH.
REQ-032 JUMP: pcsrc=10, pcwrite=1. Next state: FETCH.
REQ-033 pcen SHALL be combinational: pcwrite OR (branch AND zero). All other outputs SHALL be Moore outputs of state, except alucontrol in EXECUTE, which also depends on funct.
REQ-034 Instruction latencies, FETCH to FETCH inclusive, SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
REQ-035 States 12-15 SHALL have all outputs 0 and SHALL go to FETCH on the next edge.
REQ-036 op and funct SHALL be sampled only in DECODE, MEMADR and EXECUTE. Changes to them in any other state SHALL have no effect.

Reset
REQ-037 With reset=1 at a rising edge, state SHALL become FETCH, regardless of the current state or instruction in progress.
REQ-038 While reset=1, memwrite, regwrite, irwrite and pcen SHALL be forced to 0 combinationally, so an interrupted MEMWR or ALUWB produces no write.
REQ-039 After reset deasserts, the first cycle SHALL be FETCH with irwrite=1, pcen=1, alusrcb=01, alucontrol=010.

Verification
REQ-040 Reset, then op=001000 (addi): states 0,1,9,10,0. regwrite=1 only in state 10, with regdst=0.
REQ-041 op=000000, funct=101010 (slt): states 0,1,6,7,0. alucontrol=111 in state 6; regwrite=1 and regdst=1 in state 7.
REQ-042 op=000100 (beq), zero=1 in BRANCH: pcen=1 and pcsrc=01. Repeat with zero=0: pcen=0. Both cases return to FETCH after 3 cycles.
REQ-043 op=101011 (sw): states 0,1,2,5,0. memwrite=1 and iord=1 only in state 5. Then op=100011 (lw): states 0,1,2,3,4,0 with memtoreg=1 in state 4.
REQ-044 Assert reset while in MEMWR: memwrite=0 during that cycle and state=0 on the next edge. Also check op=111111 gives states 0,1,0 with no writes, and op=000010 (j) gives pcsrc=10 and pcen=1 in state 11.
